// File: rtl/mor1kx_cfgrs_spr_arb.sv
// mor1kx_cfgrs_spr_arb
// Read-only SPR access sequencer for the group-0 configuration registers
// (VR..AVR). It arbitrates the CPU and debug SPR requesters, decodes the
// latched address and returns registered data with a one-cycle ack/err pulse.
// It holds no configuration state of its own.
//
// Configuration macro: MOR1KX_CFGRS_DBG_PORT_EN
//   defined   : the debug port is arbitrated against the CPU (round-robin on ties)
//   undefined : debug inputs are ignored, debug outputs are tied to 0
//
// Parameters
//   OPTION_WRITE_ERR  "ENABLED": a write returns ack+err; "NONE": ack only
//   OPTION_CNT_WIDTH  width of the saturating successful-read counter
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_spr_req_i/we_i/addr_i      CPU request, write enable, {group,index} address
//   cpu_spr_ack_o/err_o/dat_o      CPU one-cycle ack, error, read data
//   dbg_spr_*                      same as cpu_spr_* for the debug unit
//   spr_vr .. spr_avr              static configuration register values
//   busy_o                         high while an access is in flight
//   rd_count_o                     count of error-free reads, saturating
module mor1kx_cfgrs_spr_arb #(
  parameter logic [8*7-1:0] OPTION_WRITE_ERR = "ENABLED",
  parameter int             OPTION_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_spr_req_i,
  input  logic                        cpu_spr_we_i,
  input  logic [15:0]                 cpu_spr_addr_i,
  output logic                        cpu_spr_ack_o,
  output logic                        cpu_spr_err_o,
  output logic [31:0]                 cpu_spr_dat_o,
  input  logic                        dbg_spr_req_i,
  input  logic                        dbg_spr_we_i,
  input  logic [15:0]                 dbg_spr_addr_i,
  output logic                        dbg_spr_ack_o,
  output logic                        dbg_spr_err_o,
  output logic [31:0]                 dbg_spr_dat_o,
  input  logic [31:0]                 spr_vr,
  input  logic [31:0]                 spr_upr,
  input  logic [31:0]                 spr_cpucfgr,
  input  logic [31:0]                 spr_dmmucfgr,
  input  logic [31:0]                 spr_immucfgr,
  input  logic [31:0]                 spr_dccfgr,
  input  logic [31:0]                 spr_iccfgr,
  input  logic [31:0]                 spr_dcfgr,
  input  logic [31:0]                 spr_pccfgr,
  input  logic [31:0]                 spr_vr2,
  input  logic [31:0]                 spr_avr,
  output logic                        busy_o,
  output logic [OPTION_CNT_WIDTH-1:0] rd_count_o
);

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_LOOKUP = 2'd1;
  localparam logic [1:0] STATE_ACK    = 2'd2;

  localparam bit WRITE_ERR_EN = (OPTION_WRITE_ERR == "ENABLED");

  logic [1:0]  state;
  logic        gnt_dbg;
  logic        we_q;
  logic [15:0] addr_q;
  logic        err_q;
  logic [31:0] data_q;

  logic        any_req;
  logic        pick_dbg;
  logic        sel_we;
  logic [15:0] sel_addr;

`ifdef MOR1KX_CFGRS_DBG_PORT_EN
  logic last_dbg;

  // On a tie the requester that was not served last wins; a lone requester
  // always wins.
  assign any_req  = cpu_spr_req_i | dbg_spr_req_i;
  assign pick_dbg = dbg_spr_req_i & (~cpu_spr_req_i | ~last_dbg);
  assign sel_we   = pick_dbg ? dbg_spr_we_i   : cpu_spr_we_i;
  assign sel_addr = pick_dbg ? dbg_spr_addr_i : cpu_spr_addr_i;

  // Grant and round-robin history; reset leaves last_dbg set so the CPU
  // takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_dbg  <= 1'b0;
      last_dbg <= 1'b1;
    end else if (state == STATE_IDLE && any_req) begin
      gnt_dbg  <= pick_dbg;
      last_dbg <= pick_dbg;
    end
  end
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_spr_req_i, dbg_spr_we_i, dbg_spr_addr_i};
  assign any_req    = cpu_spr_req_i;
  assign pick_dbg   = 1'b0;
  assign sel_we     = cpu_spr_we_i;
  assign sel_addr   = cpu_spr_addr_i;
  assign gnt_dbg    = 1'b0;
`endif

  logic        bad_addr;
  logic        good_read;
  logic [31:0] cfg_word;

  // Anything outside group 0, index 0..10 is an illegal address.
  assign bad_addr  = (addr_q[15:11] != 5'd0) || (addr_q[10:0] > 11'd10);
  assign good_read = ~bad_addr & ~we_q;

  always_comb begin
    cfg_word = 32'd0;
    case (addr_q[10:0])
      11'd0:   cfg_word = spr_vr;
      11'd1:   cfg_word = spr_upr;
      11'd2:   cfg_word = spr_cpucfgr;
      11'd3:   cfg_word = spr_dmmucfgr;
      11'd4:   cfg_word = spr_immucfgr;
      11'd5:   cfg_word = spr_dccfgr;
      11'd6:   cfg_word = spr_iccfgr;
      11'd7:   cfg_word = spr_dcfgr;
      11'd8:   cfg_word = spr_pccfgr;
      11'd9:   cfg_word = spr_vr2;
      11'd10:  cfg_word = spr_avr;
      default: cfg_word = 32'd0;
    endcase
  end

  // Access sequencer. The request is latched in IDLE so later changes on the
  // bus do not disturb the access; the decode result is registered in LOOKUP
  // and presented for exactly one cycle in ACK. The counter advances as the
  // ack is issued so it never counts an access cut short by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STATE_IDLE;
      we_q       <= 1'b0;
      addr_q     <= 16'd0;
      err_q      <= 1'b0;
      data_q     <= 32'd0;
      rd_count_o <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (any_req) begin
            we_q   <= sel_we;
            addr_q <= sel_addr;
            state  <= STATE_LOOKUP;
          end
        end
        STATE_LOOKUP: begin
          err_q  <= bad_addr | (we_q & WRITE_ERR_EN);
          data_q <= good_read ? cfg_word : 32'd0;
          if (good_read && !(&rd_count_o)) begin
            rd_count_o <= rd_count_o + 1'b1;
          end
          state  <= STATE_ACK;
        end
        STATE_ACK: begin
          state <= STATE_IDLE;
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

  logic in_ack;

  assign in_ack        = (state == STATE_ACK);
  assign busy_o        = (state != STATE_IDLE);

  assign cpu_spr_ack_o = in_ack & ~gnt_dbg;
  assign cpu_spr_err_o = in_ack & ~gnt_dbg & err_q;
  assign cpu_spr_dat_o = (in_ack & ~gnt_dbg) ? data_q : 32'd0;

  assign dbg_spr_ack_o = in_ack & gnt_dbg;
  assign dbg_spr_err_o = in_ack & gnt_dbg & err_q;
  assign dbg_spr_dat_o = (in_ack & gnt_dbg) ? data_q : 32'd0;

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_arb.sv
// tb_mor1kx_cfgrs_spr_arb
// Drives two instances from the same stimulus: dut_a with default parameters
// and dut_b with OPTION_WRITE_ERR="NONE", OPTION_CNT_WIDTH=2. Expected
// responses are pushed into a queue by the stimulus tasks and popped by a
// separate monitor whenever an ack appears.
module tb_mor1kx_cfgrs_spr_arb;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, dbg_addr;
  logic [31:0] cfg [0:10];

  logic        cpu_ack_a, cpu_err_a, dbg_ack_a, dbg_err_a, busy_a;
  logic [31:0] cpu_dat_a, dbg_dat_a;
  logic [15:0] cnt_a;
  logic        cpu_ack_b, cpu_err_b, dbg_ack_b, dbg_err_b, busy_b;
  logic [31:0] cpu_dat_b, dbg_dat_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          dbg;
    int          cyc;
    bit          ea;
    bit          eb;
    logic [31:0] d;
    int          ca;
    int          cb;
  } exp_t;

  exp_t exp_q[$];

  int model_cnt_a = 0;
  int model_cnt_b = 0;
  bit model_last_dbg = 1'b1;

  mor1kx_cfgrs_spr_arb dut_a (
    .clk(clk), .rst(rst),
    .cpu_spr_req_i(cpu_req), .cpu_spr_we_i(cpu_we), .cpu_spr_addr_i(cpu_addr),
    .cpu_spr_ack_o(cpu_ack_a), .cpu_spr_err_o(cpu_err_a), .cpu_spr_dat_o(cpu_dat_a),
    .dbg_spr_req_i(dbg_req), .dbg_spr_we_i(dbg_we), .dbg_spr_addr_i(dbg_addr),
    .dbg_spr_ack_o(dbg_ack_a), .dbg_spr_err_o(dbg_err_a), .dbg_spr_dat_o(dbg_dat_a),
    .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
    .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
    .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10]),
    .busy_o(busy_a), .rd_count_o(cnt_a)
  );

  mor1kx_cfgrs_spr_arb #(
    .OPTION_WRITE_ERR("NONE"),
    .OPTION_CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cpu_spr_req_i(cpu_req), .cpu_spr_we_i(cpu_we), .cpu_spr_addr_i(cpu_addr),
    .cpu_spr_ack_o(cpu_ack_b), .cpu_spr_err_o(cpu_err_b), .cpu_spr_dat_o(cpu_dat_b),
    .dbg_spr_req_i(dbg_req), .dbg_spr_we_i(dbg_we), .dbg_spr_addr_i(dbg_addr),
    .dbg_spr_ack_o(dbg_ack_b), .dbg_spr_err_o(dbg_err_b), .dbg_spr_dat_o(dbg_dat_b),
    .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
    .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
    .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10]),
    .busy_o(busy_b), .rd_count_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an access's outcome depends only on the address rules
  // and the write flag; the counters saturate at their own widths.
  function automatic void model_access(input logic [15:0] a, input bit we,
                                       output bit ea, output bit eb,
                                       output logic [31:0] d);
    int grp;
    int idx;
    grp = int'(a) / 2048;
    idx = int'(a) % 2048;
    if (grp != 0 || idx > 10) begin
      ea = 1'b1; eb = 1'b1; d = 32'd0;
    end else if (we) begin
      ea = 1'b1; eb = 1'b0; d = 32'd0;
    end else begin
      ea = 1'b0; eb = 1'b0; d = cfg[idx];
    end
  endfunction

  task automatic push_exp(input bit dbg, input logic [15:0] a, input bit we, input int when);
    exp_t it;
    it.dbg = dbg;
    it.cyc = when;
    model_access(a, we, it.ea, it.eb, it.d);
    if (!it.ea) begin
      if (model_cnt_a < 65535) model_cnt_a++;
      if (model_cnt_b < 3) model_cnt_b++;
    end
    it.ca = model_cnt_a;
    it.cb = model_cnt_b;
    model_last_dbg = dbg;
    exp_q.push_back(it);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = 16'($urandom_range(0, 10));
      2:       a = 16'($urandom_range(11, 2047));
      default: a = {5'($urandom_range(1, 31)), 11'($urandom_range(0, 2047))};
    endcase
    return a;
  endfunction

  // One access episode: queue the expected responses in service order, raise
  // the requests, then hold each request until its ack and drop it at the
  // edge that ends the ack cycle.
  task automatic apply_stimulus(input bit do_c, input logic [15:0] ac, input bit wc,
                                input bit do_d, input logic [15:0] ad, input bit wd);
    bit pend_c, pend_d, seen_c, seen_d, dbg_ack_ever, single;
    int k;
    int t;
    k = cyc;
    dbg_ack_ever = 1'b0;
`ifdef MOR1KX_CFGRS_DBG_PORT_EN
    if (do_c && do_d) begin
      if (model_last_dbg) begin
        push_exp(1'b0, ac, wc, k + 2);
        push_exp(1'b1, ad, wd, k + 5);
      end else begin
        push_exp(1'b1, ad, wd, k + 2);
        push_exp(1'b0, ac, wc, k + 5);
      end
    end else if (do_c) begin
      push_exp(1'b0, ac, wc, k + 2);
    end else if (do_d) begin
      push_exp(1'b1, ad, wd, k + 2);
    end
`else
    if (do_c) push_exp(1'b0, ac, wc, k + 2);
`endif
    single   = !(do_c && do_d);
    cpu_req  = do_c; cpu_addr = ac; cpu_we = wc;
    dbg_req  = do_d; dbg_addr = ad; dbg_we = wd;
    pend_c   = do_c;
    pend_d   = do_d;
    t = 0;
    while ((pend_c || pend_d) && t < 12) begin
      @(negedge clk);
      seen_c = cpu_ack_a;
      seen_d = dbg_ack_a;
      if (seen_d) dbg_ack_ever = 1'b1;
      @(posedge clk);
      #1;
      t++;
      if (seen_c && pend_c) begin
        cpu_req = 1'b0; pend_c = 1'b0;
      end
`ifdef MOR1KX_CFGRS_DBG_PORT_EN
      if (seen_d && pend_d) begin
        dbg_req = 1'b0; pend_d = 1'b0;
      end
`else
      if (pend_d && !pend_c && t >= 6) begin
        dbg_req = 1'b0; pend_d = 1'b0;
      end
`endif
      // Once granted, the lone requester's bus may wander without effect.
      if (single && t >= 1) begin
        if (pend_c) begin cpu_addr = 16'($urandom); cpu_we = 1'($urandom); end
        if (pend_d) begin dbg_addr = 16'($urandom); dbg_we = 1'($urandom); end
      end
    end
    if (pend_c || pend_d) begin
      checks++; errors++;
      $display("[TB] FAIL ack_timeout: still waiting cpu=%0b dbg=%0b after %0d cycles, required ack", pend_c, pend_d, t);
      cpu_req = 1'b0; dbg_req = 1'b0;
    end
`ifndef MOR1KX_CFGRS_DBG_PORT_EN
    if (do_d) begin
      checks++;
      if (dbg_ack_ever) begin
        errors++;
        $display("[TB] FAIL dbg_disabled_ack: got dbg ack, required none");
      end
    end
`endif
  endtask

  // Reset pulse while the access sits in LOOKUP: no ack may follow.
  task automatic reset_mid_access();
    cpu_req = 1'b1; cpu_addr = 16'h0003; cpu_we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    #2;
    rst = 1'b0;
    model_cnt_a = 0;
    model_cnt_b = 0;
    model_last_dbg = 1'b1;
    @(negedge clk);
    check_output("rst_busy", 32'(busy_a), 32'd0);
    check_output("rst_cnt_a", 32'(cnt_a), 32'd0);
    check_output("rst_cnt_b", 32'(cnt_b), 32'd0);
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: every cycle idle ports must be quiet; each ack pops one
  // expected response; the counters are compared one cycle after the ack.
  bit cnt_pend = 1'b0;
  int exp_ca = 0;
  int exp_cb = 0;

  always @(negedge clk) begin
    exp_t it;
    logic [3:0] acks;
    if (!rst) begin
      if (cnt_pend) begin
        check_output("count_a", 32'(cnt_a), 32'(exp_ca));
        check_output("count_b", 32'(cnt_b), 32'(exp_cb));
        cnt_pend = 1'b0;
      end
      check_output("quiet_ports",
                   {28'd0,
                    (!cpu_ack_a && (cpu_err_a || cpu_dat_a != 0)),
                    (!dbg_ack_a && (dbg_err_a || dbg_dat_a != 0)),
                    (!cpu_ack_b && (cpu_err_b || cpu_dat_b != 0)),
                    (!dbg_ack_b && (dbg_err_b || dbg_dat_b != 0))},
                   32'd0);
      acks = {cpu_ack_a, dbg_ack_a, cpu_ack_b, dbg_ack_b};
      if (acks != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_ack: got acks %b at cycle %0d, required none", acks, cyc);
        end else begin
          it = exp_q.pop_front();
          check_output("ack_port", 32'(acks), it.dbg ? 32'h5 : 32'hA);
          check_output("ack_cycle", 32'(cyc), 32'(it.cyc));
          check_output("err_a", 32'(it.dbg ? dbg_err_a : cpu_err_a), 32'(it.ea));
          check_output("err_b", 32'(it.dbg ? dbg_err_b : cpu_err_b), 32'(it.eb));
          check_output("dat_a", it.dbg ? dbg_dat_a : cpu_dat_a, it.d);
          check_output("dat_b", it.dbg ? dbg_dat_b : cpu_dat_b, it.d);
          exp_ca = it.ca;
          exp_cb = it.cb;
          cnt_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    bit do_c, do_d;
    int r;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'd0;
    for (int i = 0; i < 11; i++) cfg[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_busy", 32'(busy_a), 32'd0);
    check_output("reset_cnt_a", 32'(cnt_a), 32'd0);
    check_output("reset_cnt_b", 32'(cnt_b), 32'd0);

    // Simultaneous requests straight after reset: CPU first, then debug.
    apply_stimulus(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0009, 1'b0);
    // Plain CPU read of CPUCFGR.
    apply_stimulus(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0);
    // CPU write: error only where writes are flagged.
    apply_stimulus(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0);
    // Out-of-range index and non-zero group.
`ifdef MOR1KX_CFGRS_DBG_PORT_EN
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h000B, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0800, 1'b0);
`else
    apply_stimulus(1'b1, 16'h000B, 1'b0, 1'b0, 16'h0000, 1'b0);
    apply_stimulus(1'b1, 16'h0800, 1'b0, 1'b0, 16'h0000, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0);
`endif
    reset_mid_access();
    apply_stimulus(1'b1, 16'h000A, 1'b0, 1'b0, 16'h0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      do_c = (r != 2);
      do_d = (r >= 2);
      apply_stimulus(do_c, rand_addr(), ($urandom_range(0, 3) == 0),
                     do_d, rand_addr(), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
